// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the multi-port memory block: command encoding,
// default tag width and the request legality check used by every port.
// ---------------------------------------------------------------------------
package mem_pkg;

    typedef enum logic [1:0] {
        CMD_NONE  = 2'd0,
        CMD_LOAD  = 2'd1,
        CMD_STORE = 2'd2
    } cmd_t;

    localparam int TAG_WIDTH_DEF = 4;
    localparam int DATA_WIDTH    = 32;

    // A request is legal when it is word aligned and its word index lies
    // inside the storage array.
    function automatic logic addr_ok(input logic [31:0] addr,
                                     input int unsigned depth_words);
        return (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < depth_words);
    endfunction

endpackage

// File: rtl/multi_port_mem_if.sv
// ---------------------------------------------------------------------------
// multi_port_mem_if
// Per-port request/response bundle for multi_port_mem.
//   req_cmd   : command per port (CMD_NONE / CMD_LOAD / CMD_STORE)
//   req_addr  : byte address per port
//   req_wdata : store data per port
//   acc_tag   : nonzero tag when the request is accepted this cycle
//   rsp_tag   : tag of the load completing this cycle, 0 otherwise
//   rsp_data  : load data, 0 when rsp_tag is 0
// master drives requests, slave (the memory) drives tags and responses.
// ---------------------------------------------------------------------------
interface multi_port_mem_if #(
    parameter int NUM_PORTS = 2,
    parameter int TAG_WIDTH = mem_pkg::TAG_WIDTH_DEF
);
    mem_pkg::cmd_t          req_cmd   [NUM_PORTS];
    logic [31:0]            req_addr  [NUM_PORTS];
    logic [31:0]            req_wdata [NUM_PORTS];
    logic [TAG_WIDTH-1:0]   acc_tag   [NUM_PORTS];
    logic [TAG_WIDTH-1:0]   rsp_tag   [NUM_PORTS];
    logic [31:0]            rsp_data  [NUM_PORTS];

    modport master (
        output req_cmd, req_addr, req_wdata,
        input  acc_tag, rsp_tag, rsp_data
    );

    modport slave (
        input  req_cmd, req_addr, req_wdata,
        output acc_tag, rsp_tag, rsp_data
    );
endinterface

// File: rtl/mem_resp_pipe.sv
// ---------------------------------------------------------------------------
// mem_resp_pipe
// LATENCY-stage shift pipeline carrying one port's load tag and data.
// A stage holding tag 0 is an empty slot; its data is always 0 as well.
//   clk, rst : clock, synchronous active-high reset (flushes all stages)
//   in_tag   : tag entering stage 0 (0 = no load this cycle)
//   in_data  : load data entering stage 0
//   out_tag  : tag leaving the last stage
//   out_data : data leaving the last stage
// ---------------------------------------------------------------------------
module mem_resp_pipe #(
    parameter int LATENCY   = 4,
    parameter int TAG_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [TAG_WIDTH-1:0] in_tag,
    input  logic [31:0]          in_data,
    output logic [TAG_WIDTH-1:0] out_tag,
    output logic [31:0]          out_data
);

    logic [TAG_WIDTH-1:0] tag_q  [LATENCY];
    logic [31:0]          data_q [LATENCY];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            tag_q[0]  <= in_tag;
            data_q[0] <= in_data;
            for (int i = 1; i < LATENCY; i++) begin
                tag_q[i]  <= tag_q[i-1];
                data_q[i] <= data_q[i-1];
            end
        end
    end

    assign out_tag  = tag_q[LATENCY-1];
    assign out_data = data_q[LATENCY-1];

endmodule

// File: rtl/multi_port_mem.sv
// ---------------------------------------------------------------------------
// multi_port_mem
// Single shared array of 32-bit words served by NUM_PORTS independent
// request channels (port 0 instruction, port 1 data). Every port may issue
// one load or store per cycle; loads answer LATENCY cycles later with the
// tag handed out at acceptance.
//   clk : clock
//   rst : synchronous active-high reset (storage array is not cleared)
//   bus : multi_port_mem_if slave modport carrying all per-port signals
// The storage array is named unified_memory so it can be preloaded
// through a hierarchical reference.
// ---------------------------------------------------------------------------
module multi_port_mem #(
    parameter int NUM_PORTS   = 2,
    parameter int DEPTH_WORDS = 16384,
    parameter int LATENCY     = 4,
    parameter int TAG_WIDTH   = mem_pkg::TAG_WIDTH_DEF
) (
    input  logic            clk,
    input  logic            rst,
    multi_port_mem_if.slave bus
);
    import mem_pkg::*;

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    logic [31:0]          unified_memory [DEPTH_WORDS];

    logic [NUM_PORTS-1:0] accept;
    logic [NUM_PORTS-1:0] load_acc;
    logic [NUM_PORTS-1:0] store_acc;
    logic [IDX_W-1:0]     word_idx     [NUM_PORTS];
    logic [TAG_WIDTH-1:0] tag_cnt      [NUM_PORTS];
    logic [TAG_WIDTH-1:0] pipe_tag_in  [NUM_PORTS];
    logic [31:0]          pipe_data_in [NUM_PORTS];
    logic [TAG_WIDTH-1:0] pipe_tag_out [NUM_PORTS];
    logic [31:0]          pipe_data_out[NUM_PORTS];

    // Acceptance, tag hand-out and load read are all combinational from the
    // current request. The read is asynchronous, so a load sees the word as
    // it stood before any store landing on the same edge.
    always_comb begin
        accept    = '0;
        load_acc  = '0;
        store_acc = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            word_idx[p]     = bus.req_addr[p][IDX_W+1:2];
            accept[p]       = !rst && (bus.req_cmd[p] != CMD_NONE) &&
                              addr_ok(bus.req_addr[p], DEPTH_WORDS);
            load_acc[p]     = accept[p] && (bus.req_cmd[p] == CMD_LOAD);
            store_acc[p]    = accept[p] && (bus.req_cmd[p] == CMD_STORE);
            bus.acc_tag[p]  = accept[p] ? tag_cnt[p] : '0;
            pipe_tag_in[p]  = load_acc[p] ? tag_cnt[p] : '0;
            pipe_data_in[p] = load_acc[p] ? unified_memory[word_idx[p]] : '0;
            // Masked during reset so nothing leaks out before the flush edge.
            bus.rsp_tag[p]  = rst ? '0 : pipe_tag_out[p];
            bus.rsp_data[p] = rst ? '0 : pipe_data_out[p];
        end
    end

    // Tag counters skip 0, which marks "no transaction".
    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (rst) begin
                tag_cnt[p] <= TAG_WIDTH'(1);
            end else if (accept[p]) begin
                if (tag_cnt[p] == {TAG_WIDTH{1'b1}}) begin
                    tag_cnt[p] <= TAG_WIDTH'(1);
                end else begin
                    tag_cnt[p] <= tag_cnt[p] + TAG_WIDTH'(1);
                end
            end
        end
    end

    // Storage has no reset. Ports are visited in ascending order so the
    // highest-index port wins a same-word collision.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (store_acc[p]) begin
                unified_memory[word_idx[p]] <= bus.req_wdata[p];
            end
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        mem_resp_pipe #(
            .LATENCY   (LATENCY),
            .TAG_WIDTH (TAG_WIDTH)
        ) u_resp_pipe (
            .clk      (clk),
            .rst      (rst),
            .in_tag   (pipe_tag_in[p]),
            .in_data  (pipe_data_in[p]),
            .out_tag  (pipe_tag_out[p]),
            .out_data (pipe_data_out[p])
        );
    end

endmodule

// File: tb/tb_multi_port_mem.sv
// ---------------------------------------------------------------------------
// tb_multi_port_mem
// Directed bench for multi_port_mem with default parameters
// (2 ports, 16384 words, latency 4, 4-bit tags).
// ---------------------------------------------------------------------------
module tb_multi_port_mem;
    import mem_pkg::*;

    logic clk;
    logic rst;
    int   cmp_cnt;
    int   err_cnt;

    multi_port_mem_if #(.NUM_PORTS(2), .TAG_WIDTH(4)) bus ();

    multi_port_mem #(
        .NUM_PORTS   (2),
        .DEPTH_WORDS (16384),
        .LATENCY     (4),
        .TAG_WIDTH   (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required end of tests");
        $fatal(1, "watchdog expired");
    end

    task automatic idle();
        for (int p = 0; p < 2; p++) begin
            bus.req_cmd[p]   = CMD_NONE;
            bus.req_addr[p]  = '0;
            bus.req_wdata[p] = '0;
        end
    endtask

    task automatic drive(input int p, input cmd_t c, input logic [31:0] a,
                         input logic [31:0] d);
        bus.req_cmd[p]   = c;
        bus.req_addr[p]  = a;
        bus.req_wdata[p] = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(0, CMD_LOAD, 32'h10, 32'h0);
        drive(1, CMD_STORE, 32'h10, 32'h55);
        #1;
        for (int p = 0; p < 2; p++) begin
            cmp_cnt++;
            if (bus.acc_tag[p] !== 4'd0) begin
                err_cnt++;
                $display("FAIL reset_acc_tag port%0d: got %0d want 0", p, bus.acc_tag[p]);
            end
        end
        @(negedge clk);
        #1;
        for (int p = 0; p < 2; p++) begin
            cmp_cnt++;
            if (bus.rsp_tag[p] !== 4'd0 || bus.rsp_data[p] !== 32'h0) begin
                err_cnt++;
                $display("FAIL reset_rsp port%0d: got tag %0d data %h want 0/0",
                         p, bus.rsp_tag[p], bus.rsp_data[p]);
            end
        end
        idle();
        rst = 1'b0;
    endtask

    task automatic test_load_basic();
        logic [3:0]  exp_t;
        logic [31:0] exp_d;
        do_reset();
        @(negedge clk);
        drive(1, CMD_STORE, 32'h10, 32'hDEADBEEF);
        #1;
        cmp_cnt++;
        if (bus.acc_tag[1] !== 4'd1) begin
            err_cnt++;
            $display("FAIL basic_store_acc: got %0d want 1", bus.acc_tag[1]);
        end
        @(negedge clk);
        idle();
        drive(0, CMD_LOAD, 32'h10, 32'h0);
        #1;
        cmp_cnt++;
        if (bus.acc_tag[0] !== 4'd1) begin
            err_cnt++;
            $display("FAIL basic_load_acc: got %0d want 1", bus.acc_tag[0]);
        end
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            idle();
            #1;
            exp_t = (k == 4) ? 4'd1 : 4'd0;
            exp_d = (k == 4) ? 32'hDEADBEEF : 32'h0;
            cmp_cnt++;
            if (bus.rsp_tag[0] !== exp_t || bus.rsp_data[0] !== exp_d) begin
                err_cnt++;
                $display("FAIL basic_rsp cycle%0d: got tag %0d data %h want %0d/%h",
                         k, bus.rsp_tag[0], bus.rsp_data[0], exp_t, exp_d);
            end
            cmp_cnt++;
            if (bus.rsp_tag[1] !== 4'd0) begin
                err_cnt++;
                $display("FAIL basic_store_no_rsp cycle%0d: got %0d want 0", k, bus.rsp_tag[1]);
            end
        end
    endtask

    task automatic test_store_then_load();
        do_reset();
        @(negedge clk);
        drive(1, CMD_STORE, 32'h20, 32'h12345678);
        @(negedge clk);
        idle();
        drive(0, CMD_LOAD, 32'h20, 32'h0);
        #1;
        cmp_cnt++;
        if (bus.acc_tag[0] !== 4'd1) begin
            err_cnt++;
            $display("FAIL stl_acc: got %0d want 1", bus.acc_tag[0]);
        end
        repeat (3) begin
            @(negedge clk);
            idle();
        end
        @(negedge clk);
        #1;
        cmp_cnt++;
        if (bus.rsp_tag[0] !== 4'd1 || bus.rsp_data[0] !== 32'h12345678) begin
            err_cnt++;
            $display("FAIL stl_rsp: got tag %0d data %h want 1/12345678",
                     bus.rsp_tag[0], bus.rsp_data[0]);
        end
        @(negedge clk);
        #1;
        cmp_cnt++;
        if (bus.rsp_tag[0] !== 4'd0) begin
            err_cnt++;
            $display("FAIL stl_single_cycle: got tag %0d want 0", bus.rsp_tag[0]);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        @(negedge clk);
        drive(1, CMD_STORE, 32'h40, 32'h0);
        @(negedge clk);
        idle();
        drive(0, CMD_LOAD, 32'h40, 32'h0);
        drive(1, CMD_STORE, 32'h40, 32'hAAAA5555);
        #1;
        cmp_cnt++;
        if (bus.acc_tag[0] !== 4'd1 || bus.acc_tag[1] !== 4'd2) begin
            err_cnt++;
            $display("FAIL same_acc: got %0d/%0d want 1/2", bus.acc_tag[0], bus.acc_tag[1]);
        end
        @(negedge clk);
        idle();
        drive(0, CMD_LOAD, 32'h40, 32'h0);
        #1;
        cmp_cnt++;
        if (bus.acc_tag[0] !== 4'd2) begin
            err_cnt++;
            $display("FAIL same_acc2: got %0d want 2", bus.acc_tag[0]);
        end
        repeat (2) begin
            @(negedge clk);
            idle();
        end
        @(negedge clk);
        #1;
        cmp_cnt++;
        if (bus.rsp_tag[0] !== 4'd1 || bus.rsp_data[0] !== 32'h0) begin
            err_cnt++;
            $display("FAIL same_old_data: got tag %0d data %h want 1/00000000",
                     bus.rsp_tag[0], bus.rsp_data[0]);
        end
        @(negedge clk);
        #1;
        cmp_cnt++;
        if (bus.rsp_tag[0] !== 4'd2 || bus.rsp_data[0] !== 32'hAAAA5555) begin
            err_cnt++;
            $display("FAIL same_new_data: got tag %0d data %h want 2/aaaa5555",
                     bus.rsp_tag[0], bus.rsp_data[0]);
        end
    endtask

    task automatic test_store_collision();
        do_reset();
        @(negedge clk);
        drive(0, CMD_STORE, 32'h80, 32'h11111111);
        drive(1, CMD_STORE, 32'h80, 32'h22222222);
        @(negedge clk);
        idle();
        drive(0, CMD_LOAD, 32'h80, 32'h0);
        drive(1, CMD_LOAD, 32'h80, 32'h0);
        repeat (3) begin
            @(negedge clk);
            idle();
        end
        @(negedge clk);
        #1;
        for (int p = 0; p < 2; p++) begin
            cmp_cnt++;
            if (bus.rsp_tag[p] !== 4'd2 || bus.rsp_data[p] !== 32'h22222222) begin
                err_cnt++;
                $display("FAIL collision port%0d: got tag %0d data %h want 2/22222222",
                         p, bus.rsp_tag[p], bus.rsp_data[p]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  exp_t;
        logic [31:0] exp_d;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            idle();
            drive(1, CMD_STORE, 32'(i * 4), 32'hA500_0000 + 32'(i));
        end
        for (int c = 0; c < 22; c++) begin
            @(negedge clk);
            idle();
            if (c < 16) drive(0, CMD_LOAD, 32'(c * 4), 32'h0);
            #1;
            if (c < 16) begin
                exp_t = (c < 15) ? 4'(c + 1) : 4'd1;
                cmp_cnt++;
                if (bus.acc_tag[0] !== exp_t) begin
                    err_cnt++;
                    $display("FAIL b2b_acc load%0d: got %0d want %0d", c, bus.acc_tag[0], exp_t);
                end
            end
            if (c >= 4 && c < 20) begin
                exp_t = (c - 4 < 15) ? 4'(c - 3) : 4'd1;
                exp_d = 32'hA500_0000 + 32'(c - 4);
            end else begin
                exp_t = 4'd0;
                exp_d = 32'h0;
            end
            cmp_cnt++;
            if (bus.rsp_tag[0] !== exp_t || bus.rsp_data[0] !== exp_d) begin
                err_cnt++;
                $display("FAIL b2b_rsp cycle%0d: got tag %0d data %h want %0d/%h",
                         c, bus.rsp_tag[0], bus.rsp_data[0], exp_t, exp_d);
            end
        end
    endtask

    task automatic test_reject();
        do_reset();
        @(negedge clk);
        drive(1, CMD_STORE, 32'h0, 32'h0C0FFEE0);
        @(negedge clk);
        idle();
        drive(0, CMD_LOAD, 32'h3, 32'h0);
        drive(1, CMD_STORE, 32'h3, 32'hBAD0BAD0);
        #1;
        cmp_cnt++;
        if (bus.acc_tag[0] !== 4'd0 || bus.acc_tag[1] !== 4'd0) begin
            err_cnt++;
            $display("FAIL reject_misaligned: got %0d/%0d want 0/0", bus.acc_tag[0], bus.acc_tag[1]);
        end
        @(negedge clk);
        idle();
        drive(0, CMD_LOAD, 32'h0001_0000, 32'h0);
        drive(1, CMD_STORE, 32'h0001_0000, 32'hBAD1BAD1);
        #1;
        cmp_cnt++;
        if (bus.acc_tag[0] !== 4'd0 || bus.acc_tag[1] !== 4'd0) begin
            err_cnt++;
            $display("FAIL reject_range: got %0d/%0d want 0/0", bus.acc_tag[0], bus.acc_tag[1]);
        end
        @(negedge clk);
        idle();
        drive(0, CMD_LOAD, 32'h0, 32'h0);
        #1;
        cmp_cnt++;
        if (bus.acc_tag[0] !== 4'd1) begin
            err_cnt++;
            $display("FAIL reject_tag_kept: got %0d want 1", bus.acc_tag[0]);
        end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            idle();
            #1;
            if (k < 4) begin
                cmp_cnt++;
                if (bus.rsp_tag[0] !== 4'd0 || bus.rsp_tag[1] !== 4'd0) begin
                    err_cnt++;
                    $display("FAIL reject_no_rsp cycle%0d: got %0d/%0d want 0/0",
                             k, bus.rsp_tag[0], bus.rsp_tag[1]);
                end
            end else begin
                cmp_cnt++;
                if (bus.rsp_tag[0] !== 4'd1 || bus.rsp_data[0] !== 32'h0C0FFEE0) begin
                    err_cnt++;
                    $display("FAIL reject_storage: got tag %0d data %h want 1/0c0ffee0",
                             bus.rsp_tag[0], bus.rsp_data[0]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0]  exp_t;
        logic [31:0] exp_d;
        do_reset();
        @(negedge clk);
        drive(0, CMD_LOAD, 32'h0, 32'h0);
        #1;
        cmp_cnt++;
        if (bus.acc_tag[0] !== 4'd1) begin
            err_cnt++;
            $display("FAIL mid_acc0: got %0d want 1", bus.acc_tag[0]);
        end
        @(negedge clk);
        drive(0, CMD_LOAD, 32'h4, 32'h0);
        #1;
        cmp_cnt++;
        if (bus.acc_tag[0] !== 4'd2) begin
            err_cnt++;
            $display("FAIL mid_acc1: got %0d want 2", bus.acc_tag[0]);
        end
        @(negedge clk);
        rst = 1'b1;
        drive(0, CMD_LOAD, 32'h8, 32'h0);
        #1;
        cmp_cnt++;
        if (bus.acc_tag[0] !== 4'd0) begin
            err_cnt++;
            $display("FAIL mid_acc_in_reset: got %0d want 0", bus.acc_tag[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(0, CMD_LOAD, 32'hC, 32'h0);
        #1;
        cmp_cnt++;
        if (bus.acc_tag[0] !== 4'd1) begin
            err_cnt++;
            $display("FAIL mid_tag_restart: got %0d want 1", bus.acc_tag[0]);
        end
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            idle();
            #1;
            exp_t = (k == 4) ? 4'd1 : 4'd0;
            exp_d = (k == 4) ? 32'hA500_0003 : 32'h0;
            cmp_cnt++;
            if (bus.rsp_tag[0] !== exp_t || bus.rsp_data[0] !== exp_d) begin
                err_cnt++;
                $display("FAIL mid_rsp cycle%0d: got tag %0d data %h want %0d/%h",
                         k, bus.rsp_tag[0], bus.rsp_data[0], exp_t, exp_d);
            end
        end
    endtask

    initial begin
        cmp_cnt = 0;
        err_cnt = 0;
        rst     = 1'b1;
        idle();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        test_reset();
        test_load_basic();
        test_store_then_load();
        test_same_cycle();
        test_store_collision();
        test_back_to_back();
        test_reject();
        test_reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/multi_port_mem.md
MULTI_PORT_MEM -- requirements
Module: multi_port_mem

Interface
REQ-001 Parameter NUM_PORTS, default 2: number of independent request/response channels (port 0 = instruction, port 1 = data).
REQ-002 Parameter DEPTH_WORDS, default 16384: number of 32-bit words in the single shared storage array.
REQ-003 Parameter LATENCY, default 4: cycles from load acceptance to data response; legal range 1..8.
REQ-004 Parameter TAG_WIDTH, default 4: width of tag fields; tag 0 is reserved for "no transaction".
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 req_cmd  input  [NUM_PORTS][2]  per-port command: CMD_NONE, CMD_LOAD or CMD_STORE.
REQ-008 req_addr  input  [NUM_PORTS][32]  per-port byte address.
REQ-009 req_wdata  input  [NUM_PORTS][32]  per-port store data.
REQ-010 acc_tag  output  [NUM_PORTS][TAG_WIDTH]  combinational: nonzero tag when the current request is accepted, 0 when rejected or idle.
REQ-011 rsp_tag  output  [NUM_PORTS][TAG_WIDTH]  registered: tag of the load completing this cycle, 0 otherwise.
REQ-012 rsp_data  output  [NUM_PORTS][32]  registered: load data valid when rsp_tag is nonzero, 0 otherwise.

Function
REQ-013 A request SHALL be accepted iff cmd is not CMD_NONE, addr[1:0]==0 and addr[31:2] < DEPTH_WORDS; all other requests SHALL get acc_tag=0 and have no effect.
REQ-014 Each port SHALL keep a tag counter starting at 1, assign it to each accepted request, and increment it after acceptance, wrapping from 2^TAG_WIDTH-1 to 1, never 0.
REQ-015 An accepted store SHALL write req_wdata to word addr[31:2] at the accepting clock edge; stores produce no response.
REQ-016 An accepted load SHALL sample the storage word at the accepting edge and present it with its tag on rsp_tag/rsp_data exactly LATENCY cycles later, for exactly one cycle.
REQ-017 Each port SHALL accept one request per cycle with no back-pressure; the response pipeline per port holds up to LATENCY in-flight loads.
REQ-018 A load and a store to the same word in the same cycle (any ports) SHALL return the pre-store data.
REQ-019 Stores from several ports to the same word in the same cycle SHALL leave the highest-index port's data.
REQ-020 A load on a port SHALL observe every store accepted in an earlier cycle on any port.
REQ-021 Responses per port SHALL return in acceptance order; ports SHALL be fully independent in timing.

Reset
REQ-022 While rst is high: acc_tag, rsp_tag, rsp_data SHALL be 0, no requests accepted, all in-flight loads discarded without response, tag counters set to 1.
REQ-023 Reset SHALL NOT clear the storage array, which remains preloadable by $readmemh via a hierarchically visible array named unified_memory.
REQ-024 Reset asserted mid-operation SHALL drop pending responses; the first cycle after rst falls SHALL behave as a fresh start.

Structure
REQ-025 The command encoding type, CMD_* constants and tag width default SHALL live in shared package mem_pkg.
REQ-026 The per-port LATENCY-stage tag/data shift pipeline SHALL be a sub-module mem_resp_pipe, instantiated NUM_PORTS times.

Verification
REQ-027 Load port 0 addr 0x10 after preload word4=0xDEADBEEF -> acc_tag=1; 4 cycles later rsp_tag=1, rsp_data=0xDEADBEEF for one cycle.
REQ-028 Store 0x12345678 to 0x20 on port 1, load 0x20 on port 0 next cycle -> rsp_data=0x12345678.
REQ-029 Same cycle: port 0 load 0x40, port 1 store 0xAAAA5555 to 0x40 (old 0x0) -> port 0 returns 0x0; later load returns 0xAAAA5555.
REQ-030 16 back-to-back loads on port 0 -> tags 1..15 then 1; responses contiguous, in order, no tag 0.
REQ-031 Load to 0x3 and to DEPTH_WORDS*4 -> acc_tag=0, no response, no storage change.
REQ-032 Issue 3 loads, assert rst for 1 cycle after the second edge -> no responses emerge; next load gets tag 1.
